// File: rtl/sample_dma_pkg.sv
// Shared definitions for sample_dma: register indexes, CTRL/STATUS bit positions and FSM states.
package sample_dma_pkg;

   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_BASE   = 3'd1;
   localparam logic [2:0] REG_LIMIT  = 3'd2;
   localparam logic [2:0] REG_WPTR   = 3'd3;
   localparam logic [2:0] REG_COUNT  = 3'd4;
   localparam logic [2:0] REG_STATUS = 3'd5;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_CIRC    = 1;
   localparam int CTRL_CLR     = 2;
   localparam int CTRL_IRQEN   = 3;
   localparam int CTRL_IRQWRAP = 4;

   localparam int ST_BUSY    = 0;
   localparam int ST_WRAPPED = 1;
   localparam int ST_FULL    = 2;
   localparam int ST_OVERRUN = 3;
   localparam int ST_CFGERR  = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_POP   = 2'd1,
      S_LATCH = 2'd2,
      S_WRITE = 2'd3
   } state_t;

endpackage

// File: rtl/sample_dma_regs.sv
// sample_dma register file: CTRL/BASE/LIMIT, sticky status, capture start and CFGERR check, read mux.
// Defining SAMPLE_DMA_IRQ_EN adds the IRQEN/IRQWRAP control bits and the registered irq output.
module sample_dma_regs
   import sample_dma_pkg::*;
#(
   parameter int AW = 24
) (
   input  logic          clk_48,
   input  logic          irst,
   input  logic [2:0]    reg_addr,
   input  logic          reg_we,
   input  logic [31:0]   reg_wdata,
   output logic [31:0]   reg_rdata,
   input  logic          busy,
   input  logic [AW-1:0] wptr,
   input  logic [31:0]   count,
   input  logic          wrap_evt,
   input  logic          full_evt,
   input  logic          fifo_overflow,
   output logic          en,
   output logic          circ,
   output logic [AW-1:0] base,
   output logic [AW-1:0] limit,
   output logic          start
`ifdef SAMPLE_DMA_IRQ_EN
   ,
   output logic          irq
`endif
);

   logic ctrl_wr;
   logic clr;
   logic en_req;
   logic cfg_ok;
   logic wrapped;
   logic full;
   logic overrun;
   logic cfgerr;
   logic unused_wdata;

   assign ctrl_wr      = reg_we && (reg_addr == REG_CTRL);
   assign clr          = ctrl_wr && reg_wdata[CTRL_CLR];
   assign en_req       = ctrl_wr && reg_wdata[CTRL_EN] && !en;
   assign cfg_ok       = limit > base;
   assign start        = en_req && cfg_ok;
   assign unused_wdata = ^reg_wdata;

   // NOTE: non-blocking assignments so every flop sees pre-edge values; the last assignment in the block wins.
   always_ff @(posedge clk_48 or posedge irst) begin
      if (irst) begin
         en   <= 1'b0;
         circ <= 1'b0;
      end else begin
         if (ctrl_wr && !busy) circ <= reg_wdata[CTRL_CIRC];
         if (ctrl_wr && !reg_wdata[CTRL_EN]) en <= 1'b0;
         else if (start)                     en <= 1'b1;
         if (full_evt) en <= 1'b0;
      end
   end

   always_ff @(posedge clk_48 or posedge irst) begin
      if (irst) begin
         base  <= '0;
         limit <= '0;
      end else if (reg_we && !busy) begin
         if (reg_addr == REG_BASE)  base  <= reg_wdata[AW-1:0];
         if (reg_addr == REG_LIMIT) limit <= reg_wdata[AW-1:0];
      end
   end

   // Clears are applied first so an event in the same cycle always leaves its bit set.
   always_ff @(posedge clk_48 or posedge irst) begin
      if (irst) begin
         wrapped <= 1'b0;
         full    <= 1'b0;
         overrun <= 1'b0;
         cfgerr  <= 1'b0;
      end else begin
         if (clr) begin
            wrapped <= 1'b0;
            full    <= 1'b0;
            overrun <= 1'b0;
            cfgerr  <= 1'b0;
         end
         if (start) begin
            wrapped <= 1'b0;
            full    <= 1'b0;
            cfgerr  <= 1'b0;
         end
         if (en_req && !cfg_ok) cfgerr  <= 1'b1;
         if (wrap_evt)          wrapped <= 1'b1;
         if (full_evt)          full    <= 1'b1;
         if (fifo_overflow)     overrun <= 1'b1;
      end
   end

`ifdef SAMPLE_DMA_IRQ_EN
   logic irqen;
   logic irqwrap;

   always_ff @(posedge clk_48 or posedge irst) begin
      if (irst) begin
         irqen   <= 1'b0;
         irqwrap <= 1'b0;
         irq     <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            irqen   <= reg_wdata[CTRL_IRQEN];
            irqwrap <= reg_wdata[CTRL_IRQWRAP];
         end
         irq <= !clr && irqen && (full || overrun || (irqwrap && wrapped));
      end
   end
`endif

   // NOTE: default assigned first so every path drives reg_rdata and no latch is inferred.
   always_comb begin
      reg_rdata = '0;
      case (reg_addr)
         REG_CTRL: begin
            reg_rdata[CTRL_EN]   = en;
            reg_rdata[CTRL_CIRC] = circ;
`ifdef SAMPLE_DMA_IRQ_EN
            reg_rdata[CTRL_IRQEN]   = irqen;
            reg_rdata[CTRL_IRQWRAP] = irqwrap;
`endif
         end
         REG_BASE:  reg_rdata = 32'(base);
         REG_LIMIT: reg_rdata = 32'(limit);
         REG_WPTR:  reg_rdata = 32'(wptr);
         REG_COUNT: reg_rdata = count;
         REG_STATUS: begin
            reg_rdata[ST_BUSY]    = busy;
            reg_rdata[ST_WRAPPED] = wrapped;
            reg_rdata[ST_FULL]    = full;
            reg_rdata[ST_OVERRUN] = overrun;
            reg_rdata[ST_CFGERR]  = cfgerr;
         end
         default:   reg_rdata = '0;
      endcase
   end

endmodule

// File: rtl/sample_dma.sv
// Drains the sample FIFO into the SDRAM write channel over a [BASE, LIMIT) word window, one-shot or circular.
// Defining SAMPLE_DMA_IRQ_EN adds the irq output.
module sample_dma
   import sample_dma_pkg::*;
#(
   parameter int AW = 24,
   parameter int DW = 16
) (
   input  logic          clk_48,
   input  logic          irst,
   input  logic          fifo_empty,
   output logic          fifo_rd,
   input  logic [DW-1:0] fifo_data,
   input  logic          fifo_overflow,
   output logic [AW-1:0] awaddr,
   output logic [DW-1:0] wdata,
   output logic          wvalid,
   input  logic          wready,
   input  logic [2:0]    reg_addr,
   input  logic          reg_we,
   input  logic [31:0]   reg_wdata,
   output logic [31:0]   reg_rdata
`ifdef SAMPLE_DMA_IRQ_EN
   ,
   output logic          irq
`endif
);

   state_t        state;
   state_t        state_nxt;
   logic          en;
   logic          circ;
   logic          start;
   logic          busy;
   logic          hs;
   logic          at_end;
   logic          wrap_evt;
   logic          full_evt;
   logic [AW-1:0] base;
   logic [AW-1:0] limit;
   logic [AW-1:0] wptr;
   logic [31:0]   count;

   assign busy     = (state != S_IDLE);
   assign hs       = wvalid && wready;
   assign at_end   = (wptr + AW'(1)) == limit;
   assign wrap_evt = hs && at_end && circ;
   assign full_evt = hs && at_end && !circ;

   sample_dma_regs #(.AW(AW)) u_regs (
      .clk_48        (clk_48),
      .irst          (irst),
      .reg_addr      (reg_addr),
      .reg_we        (reg_we),
      .reg_wdata     (reg_wdata),
      .reg_rdata     (reg_rdata),
      .busy          (busy),
      .wptr          (wptr),
      .count         (count),
      .wrap_evt      (wrap_evt),
      .full_evt      (full_evt),
      .fifo_overflow (fifo_overflow),
      .en            (en),
      .circ          (circ),
      .base          (base),
      .limit         (limit),
      .start         (start)
`ifdef SAMPLE_DMA_IRQ_EN
      ,
      .irq           (irq)
`endif
   );

   always_ff @(posedge clk_48 or posedge irst) begin
      if (irst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // EN still reads 1 on the cycle the buffer fills, so full_evt must block the back-to-back pop.
   always_comb begin
      state_nxt = state;
      fifo_rd   = 1'b0;
      case (state)
         S_IDLE: begin
            if (en && !fifo_empty) begin
               fifo_rd   = 1'b1;
               state_nxt = S_POP;
            end
         end
         S_POP:   state_nxt = S_LATCH;
         S_LATCH: state_nxt = S_WRITE;
         S_WRITE: begin
            if (hs) begin
               if (en && !fifo_empty && !full_evt) begin
                  fifo_rd   = 1'b1;
                  state_nxt = S_POP;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_48 or posedge irst) begin
      if (irst) begin
         wvalid <= 1'b0;
         awaddr <= '0;
         wdata  <= '0;
      end else if (state == S_LATCH) begin
         wvalid <= 1'b1;
         awaddr <= wptr;
         wdata  <= fifo_data;
      end else if (hs) begin
         wvalid <= 1'b0;
      end
   end

   always_ff @(posedge clk_48 or posedge irst) begin
      if (irst) begin
         wptr  <= '0;
         count <= '0;
      end else if (start) begin
         wptr  <= base;
         count <= '0;
      end else if (hs) begin
         if (count != 32'hFFFF_FFFF) count <= count + 32'd1;
         if (at_end && circ) wptr <= base;
         else                wptr <= wptr + AW'(1);
      end
   end

endmodule

// File: tb/tb_sample_dma.sv
// Self-checking bench for sample_dma: FIFO and SDRAM-port models, window-arithmetic reference, randomized captures.
module tb_sample_dma;
   import sample_dma_pkg::*;

   localparam int AW = 24;
   localparam int DW = 16;

   logic          clk_48 = 1'b0;
   logic          irst;
   logic          fifo_empty;
   logic          fifo_rd;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_overflow;
   logic [AW-1:0] awaddr;
   logic [DW-1:0] wdata;
   logic          wvalid;
   logic          wready = 1'b0;
   logic [2:0]    reg_addr;
   logic          reg_we;
   logic [31:0]   reg_wdata;
   logic [31:0]   reg_rdata;
`ifdef SAMPLE_DMA_IRQ_EN
   logic          irq;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   sample_dma #(.AW(AW), .DW(DW)) dut (
      .clk_48        (clk_48),
      .irst          (irst),
      .fifo_empty    (fifo_empty),
      .fifo_rd       (fifo_rd),
      .fifo_data     (fifo_data),
      .fifo_overflow (fifo_overflow),
      .awaddr        (awaddr),
      .wdata         (wdata),
      .wvalid        (wvalid),
      .wready        (wready),
      .reg_addr      (reg_addr),
      .reg_we        (reg_we),
      .reg_wdata     (reg_wdata),
      .reg_rdata     (reg_rdata)
`ifdef SAMPLE_DMA_IRQ_EN
      ,
      .irq           (irq)
`endif
   );

   always #5 clk_48 = ~clk_48;

   // Sample FIFO model: dout updates on the edge that sees fifo_rd.
   logic [DW-1:0] fifo_mem [0:63];
   int            wr_ptr    = 0;
   int            rd_ptr    = 0;
   logic          flush_req = 1'b0;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk_48) begin
      if (flush_req) begin
         rd_ptr <= wr_ptr;
      end else if (fifo_rd) begin
         if (wr_ptr != rd_ptr) begin
            fifo_data <= fifo_mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
         end else begin
            fifo_data <= 16'hDEAD;
         end
      end
   end

   // Write/pop monitor sampled on the falling edge ahead of the edge that commits them.
   logic [AW-1:0] obs_addr [0:511];
   logic [DW-1:0] obs_data [0:511];
   int            obs_n = 0;
   int            rd_n  = 0;

   always @(negedge clk_48) begin
      if (!irst && wvalid && wready) begin
         obs_addr[obs_n % 512] <= awaddr;
         obs_data[obs_n % 512] <= wdata;
         obs_n                 <= obs_n + 1;
      end
      if (!irst && fifo_rd) rd_n <= rd_n + 1;
   end

   // wready policy: 0 = always ready, 1 = random stalls, 2 = held low.
   int wr_mode = 0;
   always @(posedge clk_48) begin
      #1;
      case (wr_mode)
         0:       wready = 1'b1;
         1:       wready = ($urandom_range(0, 3) != 0);
         default: wready = 1'b0;
      endcase
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_48);
      #1;
   endtask

   task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
      @(posedge clk_48);
      #1;
      reg_addr  = a;
      reg_wdata = d;
      reg_we    = 1'b1;
      @(posedge clk_48);
      #1;
      reg_we    = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
      @(negedge clk_48);
      reg_addr = a;
      #1;
      check(tag, reg_rdata, exp);
   endtask

   task automatic push(input logic [DW-1:0] d);
      fifo_mem[wr_ptr % 64] = d;
      wr_ptr                = wr_ptr + 1;
   endtask

   task automatic flush();
      @(posedge clk_48);
      #1 flush_req = 1'b1;
      @(posedge clk_48);
      #1 flush_req = 1'b0;
   endtask

   task automatic quiesce();
      wr_mode = 0;
      reg_wr(REG_CTRL, 32'h1 << CTRL_CLR);
      tick(8);
      flush();
   endtask

   task automatic wait_writes(input int s_obs, input int n, input int budget, input string tag);
      int b;
      b = budget;
      while ((obs_n - s_obs) < n && b > 0) begin
         @(negedge clk_48);
         b--;
      end
      if ((obs_n - s_obs) < n) check({tag, "_write_timeout"}, obs_n - s_obs, n);
   endtask

   task automatic wait_wvalid(input int budget, input string tag);
      int b;
      b = budget;
      while (wvalid !== 1'b1 && b > 0) begin
         @(negedge clk_48);
         b--;
      end
      if (wvalid !== 1'b1) check({tag, "_wvalid_timeout"}, wvalid, 1);
   endtask

   // Reference: the i-th accepted word lands at BASE + i (mod span when circular); one-shot stops at span words.
   task automatic run_capture(input string tag, input logic [AW-1:0] base, input logic [AW-1:0] limit,
                              input bit circ, input int n, input int mode, input bit rand_data);
      logic [DW-1:0] words [$];
      logic [DW-1:0] w;
      logic [AW-1:0] exp_wptr;
      int            span;
      int            nw;
      int            s_obs;
      int            s_rd;
      bit            wrapped;
      bit            full;
      quiesce();
      reg_wr(REG_BASE, 32'(base));
      reg_wr(REG_LIMIT, 32'(limit));
      wr_mode = mode;
      for (int i = 0; i < n; i++) begin
         w = rand_data ? DW'($urandom) : DW'(16'hA000 + i);
         words.push_back(w);
         push(w);
      end
      s_obs = obs_n;
      s_rd  = rd_n;
      reg_wr(REG_CTRL, (32'(circ) << CTRL_CIRC) | 32'h1);
      span = int'(limit - base);
      nw   = circ ? n : ((n < span) ? n : span);
      wait_writes(s_obs, nw, 30 * n + 50, tag);
      tick(12);
      check({tag, "_nwrites"}, obs_n - s_obs, nw);
      check({tag, "_npops"}, rd_n - s_rd, nw);
      for (int i = 0; i < nw; i++) begin
         check($sformatf("%s_addr%0d", tag, i), 32'(obs_addr[(s_obs + i) % 512]),
               32'(base + AW'(circ ? (i % span) : i)));
         check($sformatf("%s_data%0d", tag, i), 32'(obs_data[(s_obs + i) % 512]), 32'(words[i]));
      end
      wrapped  = circ && (n >= span);
      full     = !circ && (n >= span);
      exp_wptr = circ ? base + AW'(n % span) : (full ? limit : base + AW'(n));
      check_reg({tag, "_wptr"}, REG_WPTR, 32'(exp_wptr));
      check_reg({tag, "_count"}, REG_COUNT, nw);
      check_reg({tag, "_status"}, REG_STATUS, {27'd0, 1'b0, 1'b0, full, wrapped, 1'b0});
      check_reg({tag, "_ctrl"}, REG_CTRL, {30'd0, circ, !full});
      check({tag, "_fifo_left"}, wr_ptr - rd_ptr, n - nw);
   endtask

   initial begin : main
      logic [DW-1:0] w;
      logic [DW-1:0] w3 [0:2];
      logic [AW-1:0] rb;
      int            rspan;
      int            rn;
      bit            rc;
      int            s_obs;
      int            s_rd;

      irst          = 1'b1;
      reg_we        = 1'b0;
      reg_addr      = '0;
      reg_wdata     = '0;
      fifo_overflow = 1'b0;
      tick(3);
      check("rst_wvalid", wvalid, 0);
      check("rst_fifo_rd", fifo_rd, 0);
      check("rst_awaddr", awaddr, 0);
      check("rst_wdata", wdata, 0);
      for (int a = 0; a < 8; a++) check_reg($sformatf("rst_reg%0d", a), 3'(a), 0);
      @(posedge clk_48);
      #1 irst = 1'b0;

      run_capture("fill", 24'h100, 24'h104, 1'b0, 6, 0, 1'b0);
      run_capture("circ", 24'h010, 24'h013, 1'b1, 5, 0, 1'b1);

      // Backpressure: one word held under wready=0 for 10 cycles.
      quiesce();
      reg_wr(REG_BASE, 32'h200);
      reg_wr(REG_LIMIT, 32'h210);
      wr_mode = 2;
      tick(2);
      w = DW'($urandom);
      push(w);
      s_obs = obs_n;
      s_rd  = rd_n;
      reg_wr(REG_CTRL, 32'h1);
      wait_wvalid(20, "bp");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_48);
         check("bp_wvalid", wvalid, 1);
         check("bp_awaddr", awaddr, 32'h200);
         check("bp_wdata", wdata, w);
      end
      check("bp_no_early_write", obs_n - s_obs, 0);
      wr_mode = 0;
      wait_writes(s_obs, 1, 20, "bp");
      tick(10);
      check("bp_nwrites", obs_n - s_obs, 1);
      check("bp_npops", rd_n - s_rd, 1);
      check("bp_data", obs_data[s_obs % 512], w);

      // Empty window refuses to start, then a one-word window completes.
      quiesce();
      reg_wr(REG_BASE, 32'h20);
      reg_wr(REG_LIMIT, 32'h20);
      w = DW'($urandom);
      push(w);
      s_obs = obs_n;
      s_rd  = rd_n;
      reg_wr(REG_CTRL, 32'h1);
      tick(10);
      check_reg("cfg_status", REG_STATUS, 32'h1 << ST_CFGERR);
      check_reg("cfg_ctrl", REG_CTRL, 0);
      check("cfg_no_pop", rd_n - s_rd, 0);
      reg_wr(REG_LIMIT, 32'h21);
      reg_wr(REG_CTRL, 32'h1);
      wait_writes(s_obs, 1, 30, "cfg");
      tick(10);
      check("cfg_nwrites", obs_n - s_obs, 1);
      check("cfg_addr", obs_addr[s_obs % 512], 32'h20);
      check("cfg_data", obs_data[s_obs % 512], w);
      check_reg("cfg_status2", REG_STATUS, 32'h1 << ST_FULL);

      // Disable while a write is stalled, with an overflow pulse.
      quiesce();
      reg_wr(REG_BASE, 32'h300);
      reg_wr(REG_LIMIT, 32'h310);
      wr_mode = 2;
      tick(2);
      for (int i = 0; i < 3; i++) begin
         w3[i] = DW'($urandom);
         push(w3[i]);
      end
      s_obs = obs_n;
      s_rd  = rd_n;
      reg_wr(REG_CTRL, 32'h1);
      wait_wvalid(20, "dis");
      reg_wr(REG_CTRL, 32'h0);
      @(posedge clk_48);
      #1 fifo_overflow = 1'b1;
      @(posedge clk_48);
      #1 fifo_overflow = 1'b0;
      check("dis_wvalid_held", wvalid, 1);
      check_reg("dis_status_busy", REG_STATUS, (32'h1 << ST_BUSY) | (32'h1 << ST_OVERRUN));
      wr_mode = 0;
      wait_writes(s_obs, 1, 20, "dis");
      tick(10);
      check("dis_nwrites", obs_n - s_obs, 1);
      check("dis_npops", rd_n - s_rd, 1);
      check("dis_addr", obs_addr[s_obs % 512], 32'h300);
      check("dis_data", obs_data[s_obs % 512], w3[0]);
      check_reg("dis_status_idle", REG_STATUS, 32'h1 << ST_OVERRUN);
      check_reg("dis_ctrl", REG_CTRL, 0);
      check("dis_fifo_left", wr_ptr - rd_ptr, 2);
      reg_wr(REG_CTRL, 32'h1 << CTRL_CLR);
      check_reg("dis_clr", REG_STATUS, 0);
      @(posedge clk_48);
      #1;
      reg_addr      = REG_CTRL;
      reg_wdata     = 32'h1 << CTRL_CLR;
      reg_we        = 1'b1;
      fifo_overflow = 1'b1;
      @(posedge clk_48);
      #1;
      reg_we        = 1'b0;
      fifo_overflow = 1'b0;
      check_reg("clr_vs_ovf", REG_STATUS, 32'h1 << ST_OVERRUN);
      reg_wr(REG_CTRL, 32'h1 << CTRL_CLR);
      check_reg("clr_again", REG_STATUS, 0);

      // Randomized windows, modes and word counts under random backpressure.
      for (int k = 0; k < 8; k++) begin
         rb    = AW'($urandom_range(0, 16'hFFF0));
         rspan = $urandom_range(1, 6);
         rn    = $urandom_range(1, 10);
         rc    = ($urandom_range(0, 1) == 1);
         run_capture($sformatf("rnd%0d", k), rb, rb + AW'(rspan), rc, rn, 1, 1'b1);
      end

      // Asynchronous reset while a write is pending.
      quiesce();
      reg_wr(REG_BASE, 32'h400);
      reg_wr(REG_LIMIT, 32'h408);
      wr_mode = 2;
      tick(2);
      push(DW'($urandom));
      reg_wr(REG_CTRL, 32'h3);
      wait_wvalid(20, "arst");
      #2 irst = 1'b1;
      #1;
      check("arst_wvalid", wvalid, 0);
      check("arst_fifo_rd", fifo_rd, 0);
      for (int a = 0; a < 6; a++) begin
         reg_addr = 3'(a);
         #1;
         check($sformatf("arst_reg%0d", a), reg_rdata, 0);
      end
      @(posedge clk_48);
      #1 irst = 1'b0;
      wr_mode = 0;
      tick(5);
      check("arst_after_wvalid", wvalid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
